// File: rtl/fp36_to_fp32_cvt_pkg.sv
// Shared fp36/fp32 format constants, the operand class enum and the fp36 classifier.
// fmul_36bit is expected to import this package as well.
package fp36_pkg;

    localparam int FP36_EXP_W  = 11;
    localparam int FP36_FRAC_W = 24;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;

    localparam int FP36_BIAS = 1023;
    localparam int FP32_BIAS = 127;
    localparam int REBIAS    = FP36_BIAS - FP32_BIAS;

    localparam logic [FP32_EXP_W-1:0]  FP32_EXP_MAX   = 8'hFF;
    localparam logic [FP32_FRAC_W-1:0] FP32_QNAN_FRAC = 23'h400000;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        UDF,
        INF,
        NAN
    } fp_class_e;

    // Underflow is judged on the pre-round exponent, so fp36 denormals land in UDF too.
    function automatic fp_class_e fp36_classify(input logic [FP36_EXP_W-1:0]  e,
                                                input logic [FP36_FRAC_W-1:0] f);
        if (e == '1) begin
            return (f == '0) ? INF : NAN;
        end
        if (e == '0 && f == '0) begin
            return ZERO;
        end
        if (e <= FP36_EXP_W'(REBIAS)) begin
            return UDF;
        end
        return NORM;
    endfunction

endpackage

// File: rtl/fp36_to_fp32_cvt_if.sv
// REQ/BUSY streaming bus between fmul_36bit (master) and the fp36->fp32 narrowing stage (slave).
interface fp36_to_fp32_cvt_if;

    logic        iDATA_REQ;
    logic        oDATA_BUSY;
    logic [35:0] iDATA;
    logic        oDATA_VALID;
    logic        iDATA_BUSY;
    logic [31:0] oDATA;
    logic [2:0]  oFLAG;

    modport slave (
        input  iDATA_REQ,
        input  iDATA,
        input  iDATA_BUSY,
        output oDATA_BUSY,
        output oDATA_VALID,
        output oDATA,
        output oFLAG
    );

    modport master (
        output iDATA_REQ,
        output iDATA,
        output iDATA_BUSY,
        input  oDATA_BUSY,
        input  oDATA_VALID,
        input  oDATA,
        input  oFLAG
    );

endinterface

// File: rtl/fp36_to_fp32_cvt_fp_rne_inc.sv
// Round-to-nearest-even increment of a W-bit mantissa from {lsb, guard, sticky}.
// The carry-out tells the caller to bump the exponent; the mantissa wraps to zero in that case.
module fp_rne_inc #(
    parameter int W = 23
) (
    input  logic [W-1:0] mant_i,
    input  logic         lsb_i,
    input  logic         guard_i,
    input  logic         sticky_i,
    output logic [W-1:0] mant_o,
    output logic         carry_o
);

    logic inc;

    assign inc               = guard_i & (lsb_i | sticky_i);
    assign {carry_o, mant_o} = {1'b0, mant_i} + {{W{1'b0}}, inc};

endmodule

// File: rtl/fp36_to_fp32_cvt.sv
// Two-stage fp36 -> IEEE single converter (RNE, flush-to-zero) with REQ/BUSY flow control.
// Stage 1 classifies and rebiases; stage 2 rounds, detects overflow and packs the result.
module fp36_to_fp32_cvt
    import fp36_pkg::*;
(
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    fp36_to_fp32_cvt_if.slave bus
);

    logic adv;

    logic                   inSign;
    logic [FP36_EXP_W-1:0]  inExp;
    logic [FP36_FRAC_W-1:0] inFrac;

    logic                   s1Valid_q;
    logic                   s1Sign_q,  s1Sign_d;
    fp_class_e              s1Class_q, s1Class_d;
    logic [FP32_EXP_W-1:0]  s1Exp_q,   s1Exp_d;
    logic                   s1ExpBig_q, s1ExpBig_d;
    logic [FP32_FRAC_W-1:0] s1Frac_q,  s1Frac_d;
    logic                   s1Guard_q, s1Guard_d;

    logic [FP32_FRAC_W-1:0] rndFrac;
    logic                   rndCarry;
    logic [FP32_EXP_W:0]    expRnd;

    logic        outValid_q;
    logic [31:0] outData_q, outData_d;
    logic [2:0]  outFlag_q, outFlag_d;

    assign adv = !(outValid_q && bus.iDATA_BUSY) && !iRESET_SYNC;

    assign bus.oDATA_BUSY  = !adv;
    assign bus.oDATA_VALID = outValid_q;
    assign bus.oDATA       = outData_q;
    assign bus.oFLAG       = outFlag_q;

    assign {inSign, inExp, inFrac} = bus.iDATA;

    // Only the low 8 bits of the rebiased exponent travel on; anything at or above
    // the fp32 all-ones exponent is carried as a separate flag instead.
    always_comb begin
        s1Sign_d   = inSign;
        s1Class_d  = fp36_classify(inExp, inFrac);
        s1Exp_d    = inExp[FP32_EXP_W-1:0] - FP32_EXP_W'(REBIAS);
        s1ExpBig_d = (inExp >= FP36_EXP_W'(REBIAS + 255));
        s1Frac_d   = inFrac[FP36_FRAC_W-1:1];
        s1Guard_d  = inFrac[0];
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Class_q  <= ZERO;
            s1Exp_q    <= '0;
            s1ExpBig_q <= 1'b0;
            s1Frac_q   <= '0;
            s1Guard_q  <= 1'b0;
        end else if (adv) begin
            s1Valid_q <= bus.iDATA_REQ;
            if (bus.iDATA_REQ) begin
                s1Sign_q   <= s1Sign_d;
                s1Class_q  <= s1Class_d;
                s1Exp_q    <= s1Exp_d;
                s1ExpBig_q <= s1ExpBig_d;
                s1Frac_q   <= s1Frac_d;
                s1Guard_q  <= s1Guard_d;
            end
        end
    end

    // Guard is the dropped fp36 fraction bit; there is no sticky when narrowing 24 -> 23 bits.
    fp_rne_inc #(
        .W(FP32_FRAC_W)
    ) uRneInc (
        .mant_i   (s1Frac_q),
        .lsb_i    (s1Frac_q[0]),
        .guard_i  (s1Guard_q),
        .sticky_i (1'b0),
        .mant_o   (rndFrac),
        .carry_o  (rndCarry)
    );

    always_comb begin
        outData_d = '0;
        outFlag_d = '0;
        expRnd    = {1'b0, s1Exp_q} + {{FP32_EXP_W{1'b0}}, rndCarry};
        case (s1Class_q)
            NORM: begin
                if (s1ExpBig_q || expRnd >= (FP32_EXP_W+1)'(FP32_EXP_MAX)) begin
                    outData_d = {s1Sign_q, FP32_EXP_MAX, {FP32_FRAC_W{1'b0}}};
                    outFlag_d = 3'b101;
                end else begin
                    outData_d = {s1Sign_q, expRnd[FP32_EXP_W-1:0], rndFrac};
                    outFlag_d = {2'b00, s1Guard_q};
                end
            end
            UDF: begin
                outData_d = {s1Sign_q, 31'h0};
                outFlag_d = 3'b011;
            end
            ZERO: begin
                outData_d = {s1Sign_q, 31'h0};
            end
            INF: begin
                outData_d = {s1Sign_q, FP32_EXP_MAX, {FP32_FRAC_W{1'b0}}};
            end
            NAN: begin
                outData_d = {s1Sign_q, FP32_EXP_MAX, FP32_QNAN_FRAC};
            end
            default: begin
                outData_d = '0;
                outFlag_d = '0;
            end
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outFlag_q  <= '0;
        end else if (adv) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outData_q <= outData_d;
                outFlag_q <= outFlag_d;
            end
        end
    end

endmodule

// File: tb/tb_fp36_to_fp32_cvt.sv
// Self-checking bench for fp36_to_fp32_cvt: directed vectors, backpressure, mid-flight reset
// and a randomized stream scored against an arithmetic reference conversion.
module tb_fp36_to_fp32_cvt;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp36_to_fp32_cvt_if busIf ();

    fp36_to_fp32_cvt dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (busIf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion from the numeric rules: returns {flags, fp32}.
    function automatic logic [34:0] ref_cvt(input logic [35:0] x);
        logic        s;
        int          e;
        int unsigned f;
        int unsigned q;
        int          ex;
        bit          rem;
        s = x[35];
        e = int'(x[34:24]);
        f = int'(x[23:0]);
        if (e == 2047) begin
            return (f == 0) ? {3'b000, s, 8'hFF, 23'h0} : {3'b000, s, 8'hFF, 23'h400000};
        end
        if (e == 0 && f == 0) begin
            return {3'b000, s, 31'h0};
        end
        ex = e - 896;
        if (ex <= 0) begin
            return {3'b011, s, 31'h0};
        end
        q   = f / 2;
        rem = (f % 2) == 1;
        if (rem && (q % 2 == 1)) begin
            q = q + 1;
        end
        if (q == (1 << 23)) begin
            q  = 0;
            ex = ex + 1;
        end
        if (ex >= 255) begin
            return {3'b101, s, 8'hFF, 23'h0};
        end
        return {2'b00, rem, s, 8'(ex), 23'(q)};
    endfunction

    function automatic logic [35:0] gen_operand();
        logic [10:0] e;
        logic [23:0] f;
        int          sel;
        sel = $urandom_range(0, 9);
        f   = 24'($urandom);
        case (sel)
            0: e = 11'h7FF;
            1: begin
                e = 11'h000;
                if ($urandom_range(0, 1) == 0) f = 24'h0;
            end
            2: e = 11'($urandom_range(880, 897));
            3: e = 11'($urandom_range(1140, 1152));
            4: begin
                e = 11'($urandom_range(1145, 1150));
                f = {23'h7FFFFF, 1'($urandom)};
            end
            5: begin
                e = 11'($urandom_range(897, 1150));
                f = {f[23:2], 2'b11};
            end
            default: e = 11'($urandom_range(897, 1150));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // Sends one item with no downstream stall; lat counts rising edges from the accepting one.
    task automatic run_single(input logic [35:0] d, output logic [31:0] data,
                              output logic [2:0] flag, output int lat);
        @(negedge clk);
        busIf.iDATA      = d;
        busIf.iDATA_REQ  = 1'b1;
        busIf.iDATA_BUSY = 1'b0;
        @(negedge clk);
        busIf.iDATA_REQ = 1'b0;
        lat  = -1;
        data = '0;
        flag = '0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (busIf.oDATA_VALID) begin
                lat  = c;
                data = busIf.oDATA;
                flag = busIf.oFLAG;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busIf.iDATA_REQ  = 1'b1;
        busIf.iDATA      = 36'h3FF000000;
        busIf.iDATA_BUSY = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busIf.oDATA_VALID, busIf.oDATA, busIf.oFLAG, busIf.oDATA_BUSY} !== {1'b0, 32'h0, 3'b000, 1'b1}) begin
            failures++;
            $display("[TB] FAIL reset_state got valid=%b data=%h flag=%b busy=%b exp 0/00000000/000/1",
                     busIf.oDATA_VALID, busIf.oDATA, busIf.oFLAG, busIf.oDATA_BUSY);
        end
        @(negedge clk);
        rst = 1'b0;
        busIf.iDATA_REQ = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (busIf.oDATA_VALID !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_req_dropped cycle=%0d got valid=%b exp 0", c, busIf.oDATA_VALID);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        logic [35:0] vin  [2] = '{36'h3FF000000, 36'hC05DA8000};
        logic [31:0] vout [2] = '{32'h3F800000, 32'hC2ED4000};
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            run_single(vin[i], d, fl, lat);
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("[TB] FAIL basic_latency in=%h got=%0d exp=2", vin[i], lat);
            end
            checks++;
            if ({d, fl} !== {vout[i], 3'b000}) begin
                failures++;
                $display("[TB] FAIL basic_result in=%h got=%h/%b exp=%h/000", vin[i], d, fl, vout[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [35:0] vin  [3] = '{36'h3FF000001, 36'h3FF000003, 36'h3FFFFFFFF};
        logic [31:0] vout [3] = '{32'h3F800000, 32'h3F800002, 32'h40000000};
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_single(vin[i], d, fl, lat);
            checks++;
            if ({d, fl} !== {vout[i], 3'b001}) begin
                failures++;
                $display("[TB] FAIL rounding in=%h got=%h/%b exp=%h/001 lat=%0d", vin[i], d, fl, vout[i], lat);
            end
        end
    endtask

    task automatic test_range();
        logic [35:0] vin  [5] = '{36'h47F000000, 36'h47EFFFFFF, 36'h380000000, 36'hB80000000, 36'h000000005};
        logic [31:0] vout [5] = '{32'h7F800000, 32'h7F800000, 32'h00000000, 32'h80000000, 32'h00000000};
        logic [2:0]  vfl  [5] = '{3'b101, 3'b101, 3'b011, 3'b011, 3'b011};
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_single(vin[i], d, fl, lat);
            checks++;
            if ({d, fl} !== {vout[i], vfl[i]}) begin
                failures++;
                $display("[TB] FAIL range in=%h got=%h/%b exp=%h/%b lat=%0d", vin[i], d, fl, vout[i], vfl[i], lat);
            end
        end
    endtask

    task automatic test_specials();
        logic [35:0] vin  [3] = '{36'hFFF000000, 36'h7FF000001, 36'h800000000};
        logic [31:0] vout [3] = '{32'hFF800000, 32'h7FC00000, 32'h80000000};
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_single(vin[i], d, fl, lat);
            checks++;
            if ({d, fl} !== {vout[i], 3'b000}) begin
                failures++;
                $display("[TB] FAIL specials in=%h got=%h/%b exp=%h/000 lat=%0d", vin[i], d, fl, vout[i], lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [$];
        logic [31:0] want [3] = '{32'h3F800000, 32'h40000000, 32'h40800000};
        @(negedge clk);
        busIf.iDATA_BUSY = 1'b1;
        busIf.iDATA_REQ  = 1'b1;
        busIf.iDATA      = 36'h3FF000000;
        #1;
        checks++;
        if (busIf.oDATA_BUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_busy_empty got=%b exp=0", busIf.oDATA_BUSY);
        end
        @(negedge clk);
        busIf.iDATA = 36'h400000000;
        @(negedge clk);
        busIf.iDATA = 36'h401000000;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({busIf.oDATA_BUSY, busIf.oDATA_VALID, busIf.oDATA} !== {1'b1, 1'b1, 32'h3F800000}) begin
                failures++;
                $display("[TB] FAIL bp_stall cycle=%0d got busy=%b valid=%b data=%h exp 1/1/3f800000",
                         c, busIf.oDATA_BUSY, busIf.oDATA_VALID, busIf.oDATA);
            end
            @(negedge clk);
        end
        busIf.iDATA_BUSY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (busIf.oDATA_VALID) got.push_back(busIf.oDATA);
            @(negedge clk);
            busIf.iDATA_REQ = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("[TB] FAIL bp_count got=%0d exp=3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                failures++;
                $display("[TB] FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [2:0]  fl;
        int          lat;
        @(negedge clk);
        busIf.iDATA_BUSY = 1'b0;
        busIf.iDATA_REQ  = 1'b1;
        busIf.iDATA      = 36'h400000000;
        @(negedge clk);
        busIf.iDATA = 36'h401000000;
        @(negedge clk);
        busIf.iDATA_REQ = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (busIf.oDATA_BUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_busy got=%b exp=1", busIf.oDATA_BUSY);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busIf.oDATA_VALID, busIf.oDATA, busIf.oFLAG} !== {1'b0, 32'h0, 3'b000}) begin
            failures++;
            $display("[TB] FAIL midreset_clear got valid=%b data=%h flag=%b exp 0/00000000/000",
                     busIf.oDATA_VALID, busIf.oDATA, busIf.oFLAG);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busIf.oDATA_VALID !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_stale cycle=%0d got valid=%b data=%h exp valid=0", c, busIf.oDATA_VALID, busIf.oDATA);
            end
        end
        run_single(36'h3FF000000, d, fl, lat);
        checks++;
        if ({d, fl, lat} !== {32'h3F800000, 3'b000, 32'd2}) begin
            failures++;
            $display("[TB] FAIL midreset_after got=%h/%b lat=%0d exp=3f800000/000 lat=2", d, fl, lat);
        end
    endtask

    task automatic test_random();
        logic [34:0] sb [$];
        logic [34:0] expv;
        logic [34:0] held;
        bit          stalled;
        stalled = 1'b0;
        held    = '0;
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            busIf.iDATA_REQ  = ($urandom_range(0, 3) != 0);
            busIf.iDATA_BUSY = ($urandom_range(0, 3) == 0);
            busIf.iDATA      = gen_operand();
            #1;
            if (stalled) begin
                checks++;
                if ({busIf.oDATA_VALID, busIf.oFLAG, busIf.oDATA} !== {1'b1, held}) begin
                    failures++;
                    $display("[TB] FAIL rand_hold got=%b/%b/%h exp=1/%b/%h", busIf.oDATA_VALID, busIf.oFLAG,
                             busIf.oDATA, held[34:32], held[31:0]);
                end
            end
            if (busIf.oDATA_VALID && !busIf.iDATA_BUSY) begin
                expv = (sb.size() > 0) ? sb.pop_front() : 35'h7_FFFF_FFFF;
                checks++;
                if ({busIf.oFLAG, busIf.oDATA} !== expv) begin
                    failures++;
                    $display("[TB] FAIL rand_result got=%b/%h exp=%b/%h", busIf.oFLAG, busIf.oDATA, expv[34:32], expv[31:0]);
                end
            end
            if (busIf.iDATA_REQ && !busIf.oDATA_BUSY) sb.push_back(ref_cvt(busIf.iDATA));
            stalled = busIf.oDATA_VALID && busIf.iDATA_BUSY;
            held    = {busIf.oFLAG, busIf.oDATA};
            @(negedge clk);
        end
        busIf.iDATA_REQ  = 1'b0;
        busIf.iDATA_BUSY = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (busIf.oDATA_VALID) begin
                expv = (sb.size() > 0) ? sb.pop_front() : 35'h7_FFFF_FFFF;
                checks++;
                if ({busIf.oFLAG, busIf.oDATA} !== expv) begin
                    failures++;
                    $display("[TB] FAIL rand_drain got=%b/%h exp=%b/%h", busIf.oFLAG, busIf.oDATA, expv[34:32], expv[31:0]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand_lost got=%0d pending exp=0", sb.size());
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        busIf.iDATA_REQ  = 1'b0;
        busIf.iDATA      = '0;
        busIf.iDATA_BUSY = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
